// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial sequence detector.
// Holds the FSM state encoding, fill-counter width and counter-width default.
package seq_detect_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    localparam int FILL_W        = 4;
    localparam int CNT_W_DEFAULT = 8;

    // Saturating history-depth increment: stops at the pattern length n.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f, input int n);
        logic [FILL_W-1:0] lim;
        lim = FILL_W'(n);
        return (f >= lim) ? lim : f + 1'b1;
    endfunction

endpackage

// File: rtl/shift_in_nb.sv
// Enable-gated shift-in register with synchronous clear and flush; newest bit lands in q[0].
// Latency: one clock from en to q. Backpressure: none, en is a pure strobe.
// Clear has priority over en, and flush (with en) zeroes the history instead of shifting.
module shift_in_nb #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    input  logic         flush,
    output logic [n-1:0] q
);

    logic [n-1:0] q_q;
    logic [n-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = flush ? '0 : {q_q[n-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_detect_rx.sv
// Serial sequence detector: shifts in X on each bit_en strobe and flags a match of the last N bits against pattern.
// Latency: Z/match_cnt/armed update one clock after the strobe and hold until the next strobe or clr.
// Backpressure: none; back-to-back strobes are each one bit. Optional SEQ_DETECT_DBG_EN exposes dbg_bits/dbg_fill.
module seq_detect_rx
    import seq_detect_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             X,
    input  logic [N-1:0]     pattern,
    input  logic             overlap,
    output logic             Z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
`ifdef SEQ_DETECT_DBG_EN
    ,
    output logic [N-1:0]     dbg_bits,
    output logic [3:0]       dbg_fill
`endif
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(N);

    state_e             state_q;
    state_e             state_d;
    logic [N-1:0]       sr_q;
    logic [N-1:0]       sr_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [FILL_W-1:0]  fill_next;
    logic               z_q;
    logic               z_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               hit;
    logic               flush;

    // Compare against the history as it will be after this strobe.
    always_comb begin
        fill_next = fill_inc(fill_q, N);
        sr_d      = {sr_q[N-2:0], X};
        hit       = bit_en && (fill_next == FULL) && (sr_d == pattern);
        flush     = hit && !overlap;
    end

    shift_in_nb #(.n(N)) u_shift (
        .clk   (clk),
        .clr   (clr),
        .en    (bit_en),
        .din   (X),
        .flush (flush),
        .q     (sr_q)
    );

    always_comb begin
        fill_d = fill_q;
        z_d    = z_q;
        cnt_d  = cnt_q;
        if (bit_en) begin
            fill_d = flush ? '0 : fill_next;
            z_d    = hit;
        end
        if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            fill_q <= '0;
            z_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // A flushing hit on the Nth bit keeps us in ST_FILL.
    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            unique case (state_q)
                ST_FILL: begin
                    if ((fill_next == FULL) && !flush) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (flush) begin
                        state_d = ST_FILL;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_comb begin
        armed = (state_q == ST_ARMED);
    end

    assign Z         = z_q;
    assign match_cnt = cnt_q;

`ifdef SEQ_DETECT_DBG_EN
    assign dbg_bits = sr_q;
    assign dbg_fill = fill_q;
`endif

endmodule

// File: tb/tb_seq_detect_rx.sv
// Bench for seq_detect_rx (N=4, CNT_W=8): vector table plus hand-written corner sequences.
module tb_seq_detect_rx;

    localparam int N     = 4;
    localparam int CNT_W = 8;

    typedef struct {
        logic           clr;
        logic           en;
        logic           x;
        logic [N-1:0]   pat;
        logic           ov;
        logic           ez;
        logic [CNT_W-1:0] ec;
        logic           ea;
    } vec_t;

    typedef struct {
        logic           z;
        logic [CNT_W-1:0] cnt;
        logic           a;
    } exp_t;

    logic             clk = 1'b0;
    logic             clr;
    logic             bit_en;
    logic             X;
    logic [N-1:0]     pattern;
    logic             overlap;
    logic             Z;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;
`ifdef SEQ_DETECT_DBG_EN
    logic [N-1:0]     dbg_bits;
    logic [3:0]       dbg_fill;
`endif

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_detect_rx #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clr       (clr),
        .bit_en    (bit_en),
        .X         (X),
        .pattern   (pattern),
        .overlap   (overlap),
        .Z         (Z),
        .match_cnt (match_cnt),
        .armed     (armed)
`ifdef SEQ_DETECT_DBG_EN
        ,
        .dbg_bits  (dbg_bits),
        .dbg_fill  (dbg_fill)
`endif
    );

    function automatic vec_t mk(input logic c, input logic e, input logic x, input logic [N-1:0] p,
                                input logic ov, input logic ez, input int ec, input logic ea);
        vec_t v;
        v.clr = c; v.en = e; v.x = x; v.pat = p; v.ov = ov;
        v.ez = ez; v.ec = CNT_W'(ec); v.ea = ea;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, and compare once the DUT has updated.
    task automatic step(input vec_t v, input string nm, input int idx);
        exp_t e;
        clr     = v.clr;
        bit_en  = v.en;
        X       = v.x;
        pattern = v.pat;
        overlap = v.ov;
        e.z = v.ez; e.cnt = v.ec; e.a = v.ea;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s[%0d]: scoreboard empty", nm, idx);
        end else begin
            e = sb.pop_front();
            check({nm, "_Z"},     idx, 32'(Z),         32'(e.z));
            check({nm, "_cnt"},   idx, 32'(match_cnt), 32'(e.cnt));
            check({nm, "_armed"}, idx, 32'(armed),     32'(e.a));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        clr = 1'b1; bit_en = 1'b0; X = 1'b0; pattern = '0; overlap = 1'b0;
        @(posedge clk);
        #1;

        // Overlap on, stream 1011011: hits on strobes 4 and 7.
        tbl.push_back(mk(1, 0, 0, 4'b1011, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 1, 1, 2, 1));
        // Overlap off, same stream: flush after strobe 4, no second hit.
        tbl.push_back(mk(1, 0, 0, 4'b1011, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1011, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1011, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 0, 0, 1, 0));
        // Fourth fresh bit re-arms (history 0111, no hit); then overlap on and 0,1,1 gives 1011.
        tbl.push_back(mk(0, 1, 1, 4'b1011, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 4'b1011, 1, 1, 2, 1));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], "tbl", i);
        end

        // Idle cycles with X toggling: everything holds.
        for (int i = 0; i < 20; i++) begin
            step(mk(0, 0, i[0], 4'b1011, 1, 1, 2, 1), "idle", i);
        end
`ifdef SEQ_DETECT_DBG_EN
        check("dbg_bits", 0, 32'(dbg_bits), 32'h0000000b);
        check("dbg_fill", 0, 32'(dbg_fill), 32'd4);
`endif
        // clr wins over a simultaneous strobe.
        step(mk(1, 1, 1, 4'b1011, 1, 0, 0, 0), "clr_en", 0);

        // Partial history discarded by clr; the match needs four post-clr bits.
        step(mk(0, 1, 1, 4'b1011, 1, 0, 0, 0), "midclr", 0);
        step(mk(0, 1, 0, 4'b1011, 1, 0, 0, 0), "midclr", 1);
        step(mk(0, 1, 1, 4'b1011, 1, 0, 0, 0), "midclr", 2);
        step(mk(1, 0, 0, 4'b1011, 1, 0, 0, 0), "midclr", 3);
        step(mk(0, 1, 1, 4'b1011, 1, 0, 0, 0), "midclr", 4);
        step(mk(0, 1, 0, 4'b1011, 1, 0, 0, 0), "midclr", 5);
        step(mk(0, 1, 1, 4'b1011, 1, 0, 0, 0), "midclr", 6);
        step(mk(0, 1, 1, 4'b1011, 1, 1, 1, 1), "midclr", 7);

        // Saturation: all-ones pattern, 300 one-bits, counter stops at 255.
        step(mk(1, 0, 0, 4'b1111, 1, 0, 0, 0), "sat_clr", 0);
        for (int i = 1; i <= 300; i++) begin
            int ec;
            logic on;
            on = (i >= 4);
            ec = on ? ((i - 3) > 255 ? 255 : (i - 3)) : 0;
            step(mk(0, 1, 1, 4'b1111, 1, on, ec, on), "sat", i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_rx.md
Name: seq_detect_rx

Overview:
Serial sequence-detector receiver. It consumes the one-bit-per-strobe stream produced by the switch-scanning driver (the mux_8t1-selected switch bit, advanced on the slow clock). It shifts in bits, compares the last N bits against a programmable pattern, and raises Z on a match. Z feeds the good/bad message mux, and the match count is available for LED or 7-seg display.

Parameters:
N, 4, pattern length in bits (2..8)
CNT_W, 8, width of the saturating match counter

Ports:
clk  input  1  system clock; all state updates on rising edge
clr  input  1  synchronous active-high reset
bit_en  input  1  one-cycle strobe; X is sampled only when high
X  input  1  serial data bit
pattern  input  N  target sequence; pattern[N-1] is the oldest bit, pattern[0] the newest
overlap  input  1  1 = overlapping matches allowed; 0 = history flushed after each match
Z  output  1  match flag; registered, held between strobes
match_cnt  output  CNT_W  number of matches since clr; saturating
armed  output  1  1 when N valid bits have been received since the last flush

Behaviour:
- Reset: clr=1 at a rising edge sets sr=0, fill=0, state=ST_FILL, Z=0, match_cnt=0, armed=0. clr has priority over bit_en.
- Idle cycles: when bit_en=0, all registers hold. X is ignored.
- On bit_en=1:
  - sr_next = {sr[N-2:0], X}.
  - fill_next = min(fill+1, N).
  - hit = (fill_next==N) && (sr_next==pattern), using pattern as sampled in this same cycle.
- Latency: Z, match_cnt and armed reflect the strobe one cycle after the bit_en edge. Z holds that value until the next strobe or clr.
- Z update: Z <= hit on every strobe, so Z=0 after any non-matching strobe.
- match_cnt update: increments on hit. At 2^CNT_W-1 it holds and does not wrap.
- State machine (2 states, encoded in the package):
  - ST_FILL: armed=0; fill<N.
    - strobe with fill_next==N and no flush → ST_ARMED.
    - A hit in ST_FILL is possible on the Nth bit.
  - ST_ARMED: armed=1; every strobe is compared.
    - hit with overlap=1 → stay in ST_ARMED.
    - hit with overlap=0 → flush: fill<=0, sr<=0, go to ST_FILL.
    - no hit → stay.
  - The Nth-bit hit with overlap=0 flushes directly and stays in ST_FILL.
- Flush: Z still asserts for the matching strobe. The next match then needs N fresh bits.
- Changing overlap mid-stream takes effect at the next strobe. Changing pattern takes effect at the next comparison and does not flush history.
- clr mid-stream discards partial history. The next match needs N full bits after clr deasserts.
- bit_en held high for consecutive cycles is legal: each cycle counts as one bit.

Optional Feature:
Macro SEQ_DETECT_DBG_EN.
- Defined: adds output port dbg_bits[N-1:0] = sr, for driving the LED bank, and output dbg_fill[3:0] = fill. Both are registered, follow the same reset and hold rules, and add no latency.
- Undefined: these ports and their logic are absent. Core behaviour is identical.

Decomposition:
- Package seq_detect_pkg holds:
  - state enum (ST_FILL=1'b0, ST_ARMED=1'b1)
  - FILL_W constant (4)
  - default CNT_W (8)
- One natural sub-module, shift_in_nb #(.n(N)). It is an enable-gated, synchronously cleared shift-in register (clk, clr, en, din, flush, q) and holds sr.
- fill counter, FSM, compare, and saturating counter stay in seq_detect_rx.

Test Plan:
- N=4, pattern=4'b1011, overlap=1, clr then strobes X=1,0,1,1 → Z=1 and match_cnt=1 one cycle after the 4th strobe; Z=0, armed=0 after the 3rd strobe.
- overlap=1, stream 1,0,1,1,0,1,1 → Z=1 after strobes 4 and 7 only; match_cnt=2; armed stays 1 from strobe 4.
- overlap=0, same stream → Z=1 after strobe 4 only. armed=0 after strobe 4 and stays 0 through strobe 7 (fill=3). match_cnt=1.
- bit_en=0 for 20 cycles with X toggling every cycle → Z, match_cnt, armed and dbg_bits unchanged. clr asserted together with bit_en=1 → all outputs 0 next cycle.
- Strobes 1,0,1, then clr, then 1 → no match. Strobes 0,1,1 then give Z=1 only on the 4th post-clr bit.
- CNT_W=8, pattern 4'b1111, overlap=1, X=1 for 300 strobes → match_cnt reaches 255 and holds; Z stays 1 from strobe 4 onward.
